// File: rtl/sha1_pkg.sv
// sha1_pkg: shared SHA-1 widths, word/digest types, standard IV constants and
// the per-word feed-forward addition used after the round pipeline.
package sha1_pkg;

  localparam int unsigned SHA1_WORD_W   = 32;
  localparam int unsigned SHA1_DIGEST_W = 160;

  typedef logic [SHA1_WORD_W-1:0]   sha1_word_t;
  typedef logic [SHA1_DIGEST_W-1:0] sha1_digest_t;

  // Digest viewed as its five words, a in the most significant position.
  typedef struct packed {
    sha1_word_t a;
    sha1_word_t b;
    sha1_word_t c;
    sha1_word_t d;
    sha1_word_t e;
  } sha1_words_t;

  localparam sha1_word_t SHA1_IV_A = 32'h67452301;
  localparam sha1_word_t SHA1_IV_B = 32'hefcdab89;
  localparam sha1_word_t SHA1_IV_C = 32'h98badcfe;
  localparam sha1_word_t SHA1_IV_D = 32'h10325476;
  localparam sha1_word_t SHA1_IV_E = 32'hc3d2e1f0;

  // Final digest = raw round output + chaining value, each word mod 2^32.
  function automatic sha1_digest_t sha1_add_iv(input sha1_words_t raw,
                                               input sha1_digest_t iv);
    sha1_words_t ivw;
    sha1_words_t sum;
    ivw   = sha1_words_t'(iv);
    sum.a = raw.a + ivw.a;
    sum.b = raw.b + ivw.b;
    sum.c = raw.c + ivw.c;
    sum.d = raw.d + ivw.d;
    sum.e = raw.e + ivw.e;
    return sha1_digest_t'(sum);
  endfunction

endpackage

// File: rtl/sha1_tag_delay.sv
// sha1_tag_delay: LATENCY-deep shift register of {valid, tag} that keeps a
// candidate tag aligned with its block travelling through sha1_pipeline.
// Only the valid bits are reset; tags are plain datapath.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   in_valid,in_tag  head of the line (block entering the core)
//   tail_valid,      tail of the line, aligned with the core outputs
//   tail_tag
module sha1_tag_delay #(
  parameter int unsigned LATENCY = 80,
  parameter int unsigned TAG_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  output logic             tail_valid,
  output logic [TAG_W-1:0] tail_tag
);

  logic [LATENCY-1:0]            vld_q;
  logic [LATENCY-1:0][TAG_W-1:0] tag_q;

  if (LATENCY == 1) begin : g_single
    // Valid stage
    always_ff @(posedge clk) begin
      if (rst) vld_q <= '0;
      else     vld_q[0] <= in_valid;
    end
    // Tag stage
    always_ff @(posedge clk) begin
      tag_q[0] <= in_tag;
    end
  end else begin : g_multi
    // Valid shift, index 0 is the newest entry
    always_ff @(posedge clk) begin
      if (rst) vld_q <= '0;
      else     vld_q <= {vld_q[LATENCY-2:0], in_valid};
    end
    // Tag shift
    always_ff @(posedge clk) begin
      tag_q <= {tag_q[LATENCY-2:0], in_tag};
    end
  end

  assign tail_valid = vld_q[LATENCY-1];
  assign tail_tag   = tag_q[LATENCY-1];

endmodule

// File: rtl/sha1_match_stage.sv
// sha1_match_stage: adds the chaining IV to the sha1_pipeline round outputs,
// compares the digest against a programmed target and presents hits on a
// valid/ready result port, counting hits and flagging dropped ones.
// Optional feature macro SHA1_MATCH_MASK_EN adds target_mask for masked
// (prefix-screening) compares; without it the full 160-bit digest is compared.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid, in_tag      block entering the core and its candidate tag
//   iv                    chaining value {a,b,c,d,e}
//   hash_a..hash_e        raw core outputs, LATENCY cycles after entry
//   target                expected digest, quasi-static
//   target_mask           (SHA1_MATCH_MASK_EN only) bits taking part in compare
//   out_valid, out_ready  result handshake
//   out_tag, out_digest   held hit
//   match_count           saturating hit counter (dropped hits included)
//   overflow              sticky, a hit arrived while the result was stalled
module sha1_match_stage
  import sha1_pkg::*;
#(
  parameter int unsigned LATENCY = 80,
  parameter int unsigned TAG_W   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [TAG_W-1:0]         in_tag,
  input  logic [SHA1_DIGEST_W-1:0] iv,
  input  logic [SHA1_WORD_W-1:0]   hash_a,
  input  logic [SHA1_WORD_W-1:0]   hash_b,
  input  logic [SHA1_WORD_W-1:0]   hash_c,
  input  logic [SHA1_WORD_W-1:0]   hash_d,
  input  logic [SHA1_WORD_W-1:0]   hash_e,
  input  logic [SHA1_DIGEST_W-1:0] target,
`ifdef SHA1_MATCH_MASK_EN
  input  logic [SHA1_DIGEST_W-1:0] target_mask,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TAG_W-1:0]         out_tag,
  output logic [SHA1_DIGEST_W-1:0] out_digest,
  output logic [15:0]              match_count,
  output logic                     overflow
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  logic               tail_valid;
  logic [TAG_W-1:0]   tail_tag;

  logic               s1_valid;
  logic [TAG_W-1:0]   s1_tag;
  sha1_digest_t       s1_sum;

  sha1_digest_t       diff_c;
  logic               hit_c;

  logic [0:0]         state_q;
  logic [0:0]         state_d;
  logic               load_c;
  logic               drop_c;

  // Tag/valid delay matching the core latency
  sha1_tag_delay #(
    .LATENCY (LATENCY),
    .TAG_W   (TAG_W)
  ) u_tag_delay (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_tag     (in_tag),
    .tail_valid (tail_valid),
    .tail_tag   (tail_tag)
  );

  // S1: feed-forward addition, tag and valid registered alongside
  always_ff @(posedge clk) begin
    if (rst) s1_valid <= 1'b0;
    else     s1_valid <= tail_valid;
    s1_tag <= tail_tag;
    s1_sum <= sha1_add_iv(sha1_words_t'({hash_a, hash_b, hash_c, hash_d, hash_e}), iv);
  end

  // Compare on the S1 register; the hold register below is the second stage,
  // so a hit is visible on out_valid two cycles after the core result.
`ifdef SHA1_MATCH_MASK_EN
  assign diff_c = (s1_sum ^ target) & target_mask;
`else
  assign diff_c = s1_sum ^ target;
`endif
  assign hit_c = s1_valid && (diff_c == '0);

  // Hold register next state: load on hit when free or draining, else drop
  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    drop_c  = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (hit_c) begin
          state_d = ST_FULL;
          load_c  = 1'b1;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          if (hit_c) load_c  = 1'b1;
          else       state_d = ST_EMPTY;
        end else if (hit_c) begin
          drop_c = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Hold register, hit counter and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      out_tag     <= '0;
      out_digest  <= '0;
      match_count <= '0;
      overflow    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_c) begin
        out_tag    <= s1_tag;
        out_digest <= s1_sum;
      end
      if (hit_c && (match_count != COUNT_MAX)) match_count <= match_count + 16'd1;
      if (drop_c) overflow <= 1'b1;
    end
  end

  assign out_valid = (state_q == ST_FULL);

endmodule
